// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU: one shift-and-subtract step per cycle,
// followed by a sign-fix cycle and a one-cycle done pulse carrying HI/LO results.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   dvs_r;
    logic               qsign_r;
    logic               dsign_r;

    logic [WIDTH:0]     shifted_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH-1:0]   dvd_mag_s;
    logic [WIDTH-1:0]   dvs_mag_s;

    // Two's-complement negation when en is set; most-negative maps onto itself.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Operand magnitudes at accept and the WIDTH+1-bit trial subtraction.
    always_comb begin
        dvd_mag_s = neg_if(dividend, is_signed & dividend[WIDTH-1]);
        dvs_mag_s = neg_if(divisor,  is_signed & divisor[WIDTH-1]);
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
    end

    // Control FSM, datapath iteration and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            dvs_r       <= {WIDTH{1'b0}};
            qsign_r     <= 1'b0;
            dsign_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= {WIDTH{1'b0}};
            remainder   <= {WIDTH{1'b0}};
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        quo_r   <= dvd_mag_s;
                        dvs_r   <= dvs_mag_s;
                        rem_r   <= {WIDTH{1'b0}};
                        dsign_r <= is_signed & dividend[WIDTH-1];
                        qsign_r <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        if (divisor == {WIDTH{1'b0}}) begin
                            quotient    <= {WIDTH{1'b1}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            cnt_r       <= CNT_W'(WIDTH - 1);
                            state_r     <= ST_CALC;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_CALC: begin
                    // A clear borrow bit means the trial fits: keep it and emit a 1.
                    if (!trial_s[WIDTH]) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_FIX: begin
                    quotient  <= neg_if(quo_r, qsign_r);
                    remainder <= neg_if(rem_r, dsign_r);
                    done      <= 1'b1;
                    state_r   <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: DIV/DIVU semantics in plain 64-bit arithmetic.
    task automatic model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Issue one operation from an idle cycle; optionally pulse start at cycle 5 and on done.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input bit interfere);
        logic [31:0] eq, er;
        int cyc;
        int lat;
        model(sg, a, b, eq, er);
        lat = (b == 32'd0) ? 1 : 34;
        start     = 1'b1;
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        @(posedge clk); #1;
        start     = 1'b0;
        is_signed = ~sg;
        dividend  = $urandom;
        divisor   = $urandom;
        cyc = 1;
        chk({tag, ":busy_rise"}, {31'd0, busy}, 32'd1);
        while (!done && cyc < 60) begin
            if (interfere && cyc == 5) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom | 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, ":latency"}, cyc, lat);
        chk({tag, ":quotient"}, quotient, eq);
        chk({tag, ":remainder"}, remainder, er);
        chk({tag, ":div_by_zero"}, {31'd0, div_by_zero}, {31'd0, (b == 32'd0)});
        chk({tag, ":busy_at_done"}, {31'd0, busy}, 32'd1);
        if (interfere) begin
            start    = 1'b1;
            dividend = 32'd99;
            divisor  = 32'd0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ":done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, ":busy_fall"}, {31'd0, busy}, 32'd0);
        if (interfere) begin
            chk({tag, ":held_q"}, quotient, eq);
            chk({tag, ":held_r"}, remainder, er);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:busy", {31'd0, busy}, 32'd0);
        chk("reset:done", {31'd0, done}, 32'd0);
        chk("reset:q", quotient, 32'd0);
        chk("reset:r", remainder, 32'd0);
        chk("reset:dz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
        run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_div("s-7_-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
        run_div("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("s_dz", 1'b1, 32'h0000_1234, 32'd0, 1'b0);
        run_div("u_dz", 1'b0, 32'h0000_1234, 32'd0, 1'b0);
        run_div("clear_dz", 1'b0, 32'd81, 32'd9, 1'b0);
        run_div("interfere", 1'b0, 32'd1000, 32'd3, 1'b1);
        run_div("after_done", 1'b1, 32'hFFFF_FF00, 32'd16, 1'b0);

        // Asynchronous reset in the middle of an operation.
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd11;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst:busy", {31'd0, busy}, 32'd0);
        chk("midrst:done", {31'd0, done}, 32'd0);
        chk("midrst:q", quotient, 32'd0);
        chk("midrst:r", remainder, 32'd0);
        chk("midrst:dz", {31'd0, div_by_zero}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            chk("midrst:no_done", {31'd0, done | busy}, 32'd0);
        end
        run_div("u50_5", 1'b0, 32'd50, 32'd5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            if (i % 6 == 5) begin
                ra = 32'h8000_0000;
            end else begin
                ra = ra;
            end
            run_div($sformatf("rand%0d", i), rs, ra, rb, (i % 4 == 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
